pwm_duty_ramp: RTL and testbench

Slew-rate limiter for the PWM duty cycle, sitting between the SPI register file (source of the programmed duty byte) and the PWM peripheral (consumer of the applied duty). It takes the duty value written over SPI as a target and walks its output toward it in bounded steps at a programmable rate, so motor or LED loads never see a full-scale duty jump. Optional bypass passes the target straight through.

---
 rtl/pwm_duty_ramp.sv | 96 +++++++++
 tb/tb_pwm_duty_ramp.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_duty_ramp.sv
// Slew-rate limiter between the SPI duty register and the PWM peripheral.
// Walks duty_out toward target_duty in bounded steps, or bypasses it.
module pwm_duty_ramp #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       target_duty,
  input  logic             ramp_en,
  input  logic [3:0]       ramp_step,
  input  logic [DIV_W-1:0] ramp_div,
  output logic [7:0]       duty_out,
  output logic             busy,
  output logic             done
);

  typedef enum logic {
    S_IDLE,
    S_RAMP
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       duty_q, duty_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;

  logic signed [8:0] diff;
  logic [8:0]        mag;
  logic [3:0]        s;
  logic [7:0]        delta;
  logic [7:0]        step_val;

  // Signed 9-bit difference keeps the clamp free of wrap at 0 and 255.
  assign diff  = $signed({1'b0, target_duty}) - $signed({1'b0, duty_q});
  assign mag   = diff[8] ? 9'(-diff) : 9'(diff);
  assign s     = (ramp_step == 4'd0) ? 4'd1 : ramp_step;
  assign delta = (mag > {5'd0, s}) ? {4'd0, s} : mag[7:0];

  assign step_val = diff[8] ? (duty_q - delta) : (duty_q + delta);

  assign busy     = ramp_en && (duty_q != target_duty);
  assign duty_out = duty_q;
  assign done     = done_q;

  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    if (!ramp_en) begin
      state_d = S_IDLE;
      duty_d  = target_duty;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (busy) begin
            state_d = S_RAMP;
            cnt_d   = '0;
          end
        end
        S_RAMP: begin
          if (!busy) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end else if (cnt_q == ramp_div) begin
            cnt_d  = '0;
            duty_d = step_val;
            if (step_val == target_duty) begin
              done_d  = 1'b1;
              state_d = S_IDLE;
            end
          end else begin
            cnt_d = cnt_q + {{(DIV_W-1){1'b0}}, 1'b1};
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      duty_q  <= 8'd0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      duty_q  <= duty_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_pwm_duty_ramp.sv
// Directed bench for pwm_duty_ramp.
// Each task drives one scenario and checks against hand-derived values.
module tb_pwm_duty_ramp;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  target_duty;
  logic        ramp_en;
  logic [3:0]  ramp_step;
  logic [15:0] ramp_div;
  logic [7:0]  duty_out;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pwm_duty_ramp #(.DIV_W(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .target_duty (target_duty),
    .ramp_en     (ramp_en),
    .ramp_step   (ramp_step),
    .ramp_div    (ramp_div),
    .duty_out    (duty_out),
    .busy        (busy),
    .done        (done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bypass_to(input logic [7:0] v);
    ramp_en     = 1'b0;
    target_duty = v;
    tick();
    ramp_en = 1'b1;
  endtask

  task automatic test_reset();
    rst         = 1'b1;
    ramp_en     = 1'b1;
    target_duty = 8'h80;
    ramp_step   = 4'd1;
    ramp_div    = 16'd0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (duty_out !== 8'h00 || done !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL reset cyc%0d: duty=%h done=%b busy=%b want 00 0 1",
                 i, duty_out, done, busy);
      end
    end
  endtask

  task automatic test_bypass();
    ramp_en     = 1'b0;
    target_duty = 8'h00;
    tick();
    rst = 1'b0;
    tick();
    target_duty = 8'hC8;
    tick();
    checks++;
    if (duty_out !== 8'hC8 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL bypass: duty=%h busy=%b done=%b want c8 0 0",
               duty_out, busy, done);
    end
    tick();
    checks++;
    if (done !== 1'b0 || duty_out !== 8'hC8) begin
      errors++;
      $display("FAIL bypass_hold: duty=%h done=%b want c8 0",
               duty_out, done);
    end
  endtask

  task automatic test_ramp_up();
    logic [7:0] exp;
    bypass_to(8'd0);
    ramp_step   = 4'd10;
    ramp_div    = 16'd3;
    target_duty = 8'd100;
    tick();
    exp = 8'd0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (k % 4 == 0) exp = 8'(k / 4 * 10);
      checks++;
      if (duty_out !== exp || done !== (k == 40)) begin
        errors++;
        $display("FAIL ramp_up k=%0d: duty=%0d done=%b want %0d %b",
                 k, duty_out, done, exp, (k == 40));
      end
    end
    tick();
    checks++;
    if (duty_out !== 8'd100 || done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL ramp_up_end: duty=%0d done=%b busy=%b want 100 0 0",
               duty_out, done, busy);
    end
  endtask

  task automatic test_nonmultiple();
    logic [7:0] exp [3];
    exp[0] = 8'd10;
    exp[1] = 8'd20;
    exp[2] = 8'd25;
    bypass_to(8'd0);
    ramp_step   = 4'd10;
    ramp_div    = 16'd0;
    target_duty = 8'd25;
    tick();
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (duty_out !== exp[k] || done !== (k == 2)) begin
        errors++;
        $display("FAIL nonmult k=%0d: duty=%0d done=%b want %0d %b",
                 k, duty_out, done, exp[k], (k == 2));
      end
    end
  endtask

  task automatic test_step0_down();
    bypass_to(8'd200);
    ramp_step   = 4'd0;
    ramp_div    = 16'd0;
    target_duty = 8'd0;
    tick();
    for (int k = 1; k <= 200; k++) begin
      tick();
      checks++;
      if (duty_out !== 8'(200 - k) || done !== (k == 200)) begin
        errors++;
        $display("FAIL step0 k=%0d: duty=%0d done=%b want %0d %b",
                 k, duty_out, done, 200 - k, (k == 200));
      end
    end
    tick();
    checks++;
    if (duty_out !== 8'd0 || done !== 1'b0) begin
      errors++;
      $display("FAIL step0_floor: duty=%0d done=%b want 0 0",
               duty_out, done);
    end
  endtask

  task automatic test_retarget();
    bypass_to(8'd0);
    ramp_step   = 4'd10;
    ramp_div    = 16'd0;
    target_duty = 8'd200;
    tick();
    tick();
    tick();
    tick();
    checks++;
    if (duty_out !== 8'd30 || done !== 1'b0) begin
      errors++;
      $display("FAIL retarget_pre: duty=%0d done=%b want 30 0",
               duty_out, done);
    end
    target_duty = 8'd15;
    tick();
    checks++;
    if (duty_out !== 8'd20 || done !== 1'b0) begin
      errors++;
      $display("FAIL retarget_s1: duty=%0d done=%b want 20 0",
               duty_out, done);
    end
    tick();
    checks++;
    if (duty_out !== 8'd15 || done !== 1'b1) begin
      errors++;
      $display("FAIL retarget_s2: duty=%0d done=%b want 15 1",
               duty_out, done);
    end
    tick();
    checks++;
    if (duty_out !== 8'd15 || done !== 1'b0) begin
      errors++;
      $display("FAIL retarget_after: duty=%0d done=%b want 15 0",
               duty_out, done);
    end
  endtask

  task automatic test_retarget_equal();
    bypass_to(8'd0);
    ramp_step   = 4'd10;
    ramp_div    = 16'd0;
    target_duty = 8'd100;
    tick();
    tick();
    tick();
    tick();
    target_duty = 8'd30;
    tick();
    checks++;
    if (duty_out !== 8'd30 || done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL retarget_eq: duty=%0d done=%b busy=%b want 30 0 0",
               duty_out, done, busy);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] exp;
    bypass_to(8'd0);
    ramp_step   = 4'd10;
    ramp_div    = 16'd1;
    target_duty = 8'd100;
    tick();
    for (int k = 0; k < 12; k++) tick();
    checks++;
    if (duty_out !== 8'd60) begin
      errors++;
      $display("FAIL rst_mid_pre: duty=%0d want 60", duty_out);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (duty_out !== 8'd0 || done !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid: duty=%0d done=%b want 0 0", duty_out, done);
    end
    rst = 1'b0;
    tick();
    exp = 8'd0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k % 2 == 0) exp = 8'(k / 2 * 10);
      checks++;
      if (duty_out !== exp || done !== (k == 20)) begin
        errors++;
        $display("FAIL rst_resume k=%0d: duty=%0d done=%b want %0d %b",
                 k, duty_out, done, exp, (k == 20));
      end
    end
  endtask

  task automatic test_bypass_midramp();
    bypass_to(8'd0);
    ramp_step   = 4'd5;
    ramp_div    = 16'd0;
    target_duty = 8'd50;
    tick();
    tick();
    tick();
    ramp_en = 1'b0;
    tick();
    checks++;
    if (duty_out !== 8'd50 || done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL bypass_mid: duty=%0d done=%b busy=%b want 50 0 0",
               duty_out, done, busy);
    end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_ramp_up();
    test_nonmultiple();
    test_step0_down();
    test_retarget();
    test_retarget_equal();
    test_reset_mid();
    test_bypass_midramp();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
